// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: FSM encoding, latency bounds and counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_ctrl_pkg;

   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 15;
   localparam int CNT_W       = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      ACK     = 2'd2,
      RELEASE = 2'd3
   } state_t;

   // Clamp a requested latency into the supported range.
   function automatic int latency_clamp(input int lat);
      if (lat < LATENCY_MIN) return LATENCY_MIN;
      if (lat > LATENCY_MAX) return LATENCY_MAX;
      return lat;
   endfunction

   // BUSY countdown start value; the accept edge and the ACK-entry edge are not counted.
   function automatic logic [CNT_W-1:0] latency_load(input int lat);
      if (lat < 2) return '0;
      return CNT_W'(lat - 2);
   endfunction

endpackage

// File: rtl/mem_ctrl_ram.sv
// Single-port synchronous 32-bit word store, 2^ADDR_WIDTH deep; contents are never reset.
// Latency: write lands and read data registers on the same enabled edge.
// Backpressure: none; one access per enabled edge, rdata holds between reads.
module mem_ctrl_ram #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [31:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: latches a read/write, accesses the RAM LATENCY edges later, 4-phase ack; MEM_CTRL_STATS_EN adds counters.
// Latency: mem_ack high in the cycle LATENCY edges after acceptance (the accept edge counts as the first).
// Backpressure: requests are held until ack and must drop before another is taken; input changes while busy are ignored.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int LATENCY    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_write_data,
   output logic [31:0] mem_read_data,
   output logic        mem_ack,
   output logic        mem_err,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count
);

   localparam int               LAT_EFF  = latency_clamp(LATENCY);
   localparam logic [CNT_W-1:0] CNT_LOAD = latency_load(LAT_EFF);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    req;
   logic                    accept;
   logic                    access;

   logic                    bus_oor;
   logic                    bus_bad;

   logic                    lat_wr_q;
   logic                    lat_oor_q;
   logic [ADDR_WIDTH-1:0]   lat_idx_q;
   logic [31:0]             lat_wdata_q;

   logic                    from_bus;
   logic                    acc_wr;
   logic                    acc_oor;
   logic [ADDR_WIDTH-1:0]   acc_idx;
   logic [31:0]             acc_wdata;

   logic                    ram_en;
   logic [31:0]             ram_rdata;
   logic                    rd_blank_q;
   logic                    err_q;

   assign req     = mem_read | mem_write;
   assign bus_oor = |mem_addr[31:ADDR_WIDTH+2];
   assign bus_bad = bus_oor | (|mem_addr[1:0]) | (mem_read & mem_write);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      access  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               accept = 1'b1;
               if (LAT_EFF == 1) begin
                  access  = 1'b1;
                  state_d = ACK;
               end else begin
                  cnt_d   = CNT_LOAD;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               access  = 1'b1;
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ACK: begin
            state_d = RELEASE;
         end
         RELEASE: begin
            if (!req) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A write wins when both request lines are raised together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_wr_q    <= 1'b0;
         lat_oor_q   <= 1'b0;
         lat_idx_q   <= '0;
         lat_wdata_q <= '0;
      end else if (accept) begin
         lat_wr_q    <= mem_write;
         lat_oor_q   <= bus_oor;
         lat_idx_q   <= mem_addr[ADDR_WIDTH+1:2];
         lat_wdata_q <= mem_write_data;
      end
   end

   // Only a LATENCY of 1 accesses on the accept edge, straight from the bus.
   assign from_bus  = (state_q == IDLE);
   assign acc_wr    = from_bus ? mem_write                  : lat_wr_q;
   assign acc_oor   = from_bus ? bus_oor                    : lat_oor_q;
   assign acc_idx   = from_bus ? mem_addr[ADDR_WIDTH+1:2]   : lat_idx_q;
   assign acc_wdata = from_bus ? mem_write_data             : lat_wdata_q;

   assign ram_en = access & ~acc_oor & reset;

   mem_ctrl_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (acc_wr),
      .addr  (acc_idx),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

   // The RAM output register is not reset, so a flag zeroes the read port after reset or an out-of-range read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_blank_q <= 1'b1;
      end else if (access && !acc_wr) begin
         rd_blank_q <= acc_oor;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (accept && bus_bad) begin
         err_q <= 1'b1;
      end
   end

   assign mem_read_data = rd_blank_q ? 32'd0 : ram_rdata;
   assign mem_ack       = (state_q == ACK);
   assign mem_err       = err_q;

`ifdef MEM_CTRL_STATS_EN
   logic [31:0] rd_cnt_q;
   logic [31:0] wr_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else if (access) begin
         if (acc_wr) begin
            wr_cnt_q <= wr_cnt_q + 32'd1;
         end else begin
            rd_cnt_q <= rd_cnt_q + 32'd1;
         end
      end
   end

   assign rd_count = rd_cnt_q;
   assign wr_count = wr_cnt_q;
`else
   assign rd_count = 32'd0;
   assign wr_count = 32'd0;
`endif

endmodule
